mem_burst_arbiter: RTL and testbench
====================================

Name: mem_burst_arbiter

Overview:
- N-channel arbiter between per-channel cache line ports (dfp side) and the single burst memory port (bmem side).
- Successor to the fixed two-cache, 256/64-bit arbiter in the pipelined core's cache unit.
- Parametrised channel count, line width and bus width; round-robin fairness; ready-stall handling on reads and writes.
- One transaction outstanding at a time; each line moves as LINE_W/BUS_W beats.

Parameters:
- N_CH, 2, number of requesting channels (>=2).
- ADDR_W, 32, address width.
- LINE_W, 256, cache line width in bits.
- BUS_W, 64, memory data bus width; LINE_W must be a multiple of BUS_W.
- Derived: BEATS = LINE_W/BUS_W; CH_W = $clog2(N_CH); CNT_W = $clog2(BEATS)+1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_addr  in  N_CH*ADDR_W  per-channel line address; channel i at slice [i*ADDR_W +: ADDR_W].
- req_read  in  N_CH  per-channel line read request, level, held until resp.
- req_write  in  N_CH  per-channel line write request, level, held until resp.
- req_wdata  in  N_CH*LINE_W  per-channel write line.
- req_rdata  out  LINE_W  read line, shared by all channels, valid with req_resp.
- req_resp  out  N_CH  one-hot completion pulse, one cycle.
- busy  out  1  high whenever state != IDLE.
- grant  out  CH_W  channel currently owned; holds last value in IDLE.
- bmem_addr  out  ADDR_W  burst address.
- bmem_read  out  1  read command, one accepted cycle per burst.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  BUS_W  write beat.
- bmem_ready  in  1  memory accepts command/beat this cycle.
- bmem_rdata  in  BUS_W  read beat.
- bmem_rvalid  in  1  read beat valid.

Behaviour:
- Reset values: state=IDLE; all outputs 0; rr_ptr=0; beat counter=0; line buffer=0.
- States: IDLE, RD_CMD, RD_DATA, WR_DATA, RESP.
- IDLE:
  - A channel is pending if req_read|req_write.
  - Winner = first pending channel at or after rr_ptr, searching upward modulo N_CH.
  - Latch grant, address, op and wdata (if write); clear beat counter.
  - Next state: WR_DATA if req_write, else RD_CMD. If both are set, the write is serviced; the read is not separately answered.
  - Arbitration costs exactly one cycle; no bmem activity in IDLE.
- RD_CMD:
  - bmem_read=1; bmem_addr=latched address.
  - bmem_ready=1 -> RD_DATA. bmem_ready=0 -> stay with command held.
- RD_DATA:
  - bmem_addr stays on the latched address; bmem_read=0.
  - On each bmem_rvalid, store bmem_rdata into buffer[cnt*BUS_W +: BUS_W] and increment cnt.
  - rvalid is accepted regardless of bmem_ready. Gaps in rvalid are tolerated.
  - After the BEATS-th beat -> RESP.
- WR_DATA:
  - bmem_write=1; bmem_addr=latched address; bmem_wdata=wbuf[cnt*BUS_W +: BUS_W].
  - Beat advances only when bmem_ready=1; with ready=0 the beat and address are held.
  - After the BEATS-th accepted beat -> RESP.
- RESP:
  - req_resp[grant]=1 for exactly one cycle; req_rdata=buffer (reads; don't-care for writes).
  - rr_ptr = grant+1 modulo N_CH; next state IDLE.
- Latency: minimum read completion = 1 (arb) + 1 (cmd) + BEATS (data) + 1 (resp) cycles. Minimum write = 1 + BEATS + 1.
- Requestor contract:
  - Inputs are sampled only in IDLE.
  - The requestor deasserts its request by the cycle after resp; a request still high in that IDLE cycle is a new request.
  - Address and wdata changes after the grant cycle are ignored.
- Fairness: with all channels continuously requesting, grants rotate 0,1,...,N_CH-1; no channel waits more than N_CH-1 transactions.
- req_rdata holds the last read line until the next read overwrites it.
- Reset mid-burst: immediate return to IDLE, outputs zero, in-flight data discarded, no resp. Memory-side cleanup is the memory model's concern.
- Unused rvalid outside RD_DATA is ignored; bmem_ready outside RD_CMD/WR_DATA is ignored.

Decomposition:
- Package mem_arb_pkg:
  - state enum arb_state_t (IDLE, RD_CMD, RD_DATA, WR_DATA, RESP).
  - Default width localparams.
- Sub-module rr_arbiter (N parameter): req vector and ptr in; grant index and any_req out; purely combinational.
- Instantiated once.

Test Plan:
- Single read, channel 0, addr 0x0000_1000, BEATS=4, ready=1, beats 0xA..0xD -> bmem_read high one cycle at the address; req_resp[0] 7 cycles after request; req_rdata = {0xD,0xC,0xB,0xA}.
- Write, channel 1, line {0x4,0x3,0x2,0x1}, ready low on the 2nd beat for 3 cycles -> bmem_wdata sequence 0x1, 0x2 (held 4 cycles), 0x3, 0x4; req_resp[1] once.
- All 3 channels requesting reads continuously (N_CH=3) -> grant order 0,1,2,0; each resp one-hot, one cycle.
- Channel requests read and write together -> write burst only; single resp; rr_ptr advances.
- rst asserted on the 2nd read beat -> next cycle busy=0, no resp; a new request then completes normally.
- Read with rvalid gaps (valid, idle, idle, valid, valid, valid) -> correct line assembled; resp one cycle after the 4th beat.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the burst memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    RESP    = 3'd4
  } arb_state_t;

  localparam int DEF_N_CH   = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 256;
  localparam int DEF_BUS_W  = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int CW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [CW-1:0] grant,
  output logic          any_req
);

  // Scanning from the far end downward lets the nearest requester win last.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        grant   = CW'((int'(ptr) + i) % N);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_burst_arbiter.sv
// N-channel cache-line arbiter onto a single burst memory port, one transaction at a time.
//   state   | meaning
//   IDLE    | arbitrate pending channels, latch address/op/wdata
//   RD_CMD  | hold read command until memory accepts it
//   RD_DATA | collect LINE_W/BUS_W read beats on rvalid
//   WR_DATA | present write beats, advance on ready
//   RESP    | one-cycle completion pulse to the granted channel
module mem_burst_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int N_CH   = DEF_N_CH,
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int LINE_W = DEF_LINE_W,
  parameter  int BUS_W  = DEF_BUS_W,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*ADDR_W-1:0]   req_addr,
  input  logic [N_CH-1:0]          req_read,
  input  logic [N_CH-1:0]          req_write,
  input  logic [N_CH*LINE_W-1:0]   req_wdata,
  output logic [LINE_W-1:0]        req_rdata,
  output logic [N_CH-1:0]          req_resp,
  output logic                     busy,
  output logic [CH_W-1:0]          grant,
  output logic [ADDR_W-1:0]        bmem_addr,
  output logic                     bmem_read,
  output logic                     bmem_write,
  output logic [BUS_W-1:0]         bmem_wdata,
  input  logic                     bmem_ready,
  input  logic [BUS_W-1:0]         bmem_rdata,
  input  logic                     bmem_rvalid
);

  localparam int BEATS = LINE_W / BUS_W;
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);

  arb_state_t        state, state_n;
  logic [CH_W-1:0]   grant_q, rr_ptr, arb_grant;
  logic              arb_any;
  logic [N_CH-1:0]   pending;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wbuf, rbuf;
  logic [CNT_W-1:0]  cnt;

  assign pending = req_read | req_write;

  rr_arbiter #(.N(N_CH), .CW(CH_W)) u_rr (
    .req     (pending),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (arb_any) state_n = req_write[arb_grant] ? WR_DATA : RD_CMD;
      RD_CMD:  if (bmem_ready) state_n = RD_DATA;
      RD_DATA: if (bmem_rvalid && cnt == LAST_BEAT) state_n = RESP;
      WR_DATA: if (bmem_ready && cnt == LAST_BEAT) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request-side inputs are only looked at here; later changes by the requestor are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      rr_ptr  <= '0;
      addr_q  <= '0;
      wbuf    <= '0;
      rbuf    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (arb_any) begin
          grant_q <= arb_grant;
          addr_q  <= req_addr[arb_grant*ADDR_W +: ADDR_W];
          if (req_write[arb_grant]) wbuf <= req_wdata[arb_grant*LINE_W +: LINE_W];
          cnt     <= '0;
        end
        RD_DATA: if (bmem_rvalid) begin
          rbuf[cnt*BUS_W +: BUS_W] <= bmem_rdata;
          cnt <= cnt + CNT_W'(1);
        end
        WR_DATA: if (bmem_ready) cnt <= cnt + CNT_W'(1);
        RESP:    rr_ptr <= (grant_q == LAST_CH) ? '0 : grant_q + CH_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    busy       = (state != IDLE);
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    req_resp   = '0;
    case (state)
      RD_CMD: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
      end
      RD_DATA: bmem_addr = addr_q;
      WR_DATA: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = wbuf[cnt*BUS_W +: BUS_W];
      end
      RESP:    req_resp = N_CH'(1) << grant_q;
      default: ;
    endcase
  end

  assign grant     = grant_q;
  assign req_rdata = rbuf;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed + randomized bench for mem_burst_arbiter (3 channels, 4 beats per line),
// with a round-robin / burst reference model computed from the arbitration rules.
module tb_mem_burst_arbiter;

  localparam int N_CH   = 3;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int BUS_W  = 64;
  localparam int BEATS  = LINE_W / BUS_W;
  localparam int CH_W   = $clog2(N_CH);
  localparam int W      = LINE_W;

  logic                   clk, rst;
  logic [N_CH*ADDR_W-1:0] req_addr;
  logic [N_CH-1:0]        req_read, req_write;
  logic [N_CH*LINE_W-1:0] req_wdata;
  logic [LINE_W-1:0]      req_rdata;
  logic [N_CH-1:0]        req_resp;
  logic                   busy;
  logic [CH_W-1:0]        grant;
  logic [ADDR_W-1:0]      bmem_addr;
  logic                   bmem_read, bmem_write;
  logic [BUS_W-1:0]       bmem_wdata;
  logic                   bmem_ready;
  logic [BUS_W-1:0]       bmem_rdata;
  logic                   bmem_rvalid;

  mem_burst_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .BUS_W(BUS_W)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_read(req_read), .req_write(req_write), .req_wdata(req_wdata),
    .req_rdata(req_rdata), .req_resp(req_resp), .busy(busy), .grant(grant),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rdata(bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int failures = 0;
  int model_ptr = 0;
  int gap_cfg [BEATS];
  logic [BUS_W-1:0] beat_val [BEATS];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N_CH-1:0] pend, input int ptr);
    for (int i = 0; i < N_CH; i++)
      if (pend[(ptr + i) % N_CH]) return (ptr + i) % N_CH;
    return -1;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One whole transaction; rst_beat >= 0 aborts the read with a reset while that beat is offered.
  task automatic run_txn(input int cmd_stall, input int wst_at, input int wst_len,
                         input bit rnd, input int rst_beat);
    logic [N_CH-1:0]   pend, oh;
    logic [ADDR_W-1:0] aexp;
    logic [LINE_W-1:0] wexp, line;
    logic [BUS_W-1:0]  bv;
    int ch, edges, waits, k, g, held;
    bit is_wr, rdy;
    pend  = req_read | req_write;
    ch    = rr_pick(pend, model_ptr);
    is_wr = req_write[ch];
    aexp  = req_addr[ch*ADDR_W +: ADDR_W];
    wexp  = req_wdata[ch*LINE_W +: LINE_W];
    edges = 0;
    waits = 0;
    line  = '0;
    tick(); edges++;
    chk("busy_arb", W'(busy), W'(1));
    chk("grant", W'(grant), W'(ch));
    if (rnd) begin
      for (int c = 0; c < N_CH; c++) begin
        req_addr[c*ADDR_W +: ADDR_W] = $urandom;
        req_wdata[c*LINE_W +: LINE_W] = rand_line();
      end
    end
    if (!is_wr) begin
      for (int s = 0; s <= cmd_stall; s++) begin
        chk("rd_cmd", W'(bmem_read), W'(1));
        chk("rd_addr", W'(bmem_addr), W'(aexp));
        bmem_ready = (s == cmd_stall);
        tick(); edges++;
      end
      waits += cmd_stall;
      bmem_ready = 1'b0;
      chk("rd_cmd_drop", W'(bmem_read), W'(0));
      for (k = 0; k < BEATS; k++) begin
        g = rnd ? int'($urandom_range(0, 2)) : gap_cfg[k];
        for (int j = 0; j < g; j++) begin
          bmem_rvalid = 1'b0;
          bmem_ready  = 1'($urandom_range(0, 1));
          bmem_rdata  = {$urandom, $urandom};
          tick(); edges++; waits++;
        end
        bv = rnd ? {$urandom, $urandom} : beat_val[k];
        bmem_rvalid = 1'b1;
        bmem_rdata  = bv;
        line[k*BUS_W +: BUS_W] = bv;
        if (k == rst_beat) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          bmem_rvalid = 1'b0;
          chk("rst_busy", W'(busy), W'(0));
          chk("rst_resp", W'(req_resp), W'(0));
          chk("rst_bmem_read", W'(bmem_read), W'(0));
          chk("rst_grant", W'(grant), W'(0));
          chk("rst_rdata", req_rdata, W'(0));
          model_ptr = 0;
          return;
        end
        tick(); edges++;
      end
      bmem_rvalid = 1'b0;
    end else begin
      k = 0;
      held = 0;
      while (k < BEATS) begin
        chk("wr_valid", W'(bmem_write), W'(1));
        chk("wr_addr", W'(bmem_addr), W'(aexp));
        chk("wr_beat", W'(bmem_wdata), W'(wexp[k*BUS_W +: BUS_W]));
        if (rnd) rdy = ($urandom_range(0, 3) != 0) || (held >= 8);
        else     rdy = !(k == wst_at && held < wst_len);
        if (!rdy) begin held++; waits++; end
        bmem_ready = rdy;
        tick(); edges++;
        if (rdy) k++;
      end
      bmem_ready = 1'b0;
    end
    oh = '0;
    oh[ch] = 1'b1;
    chk("resp_onehot", W'(req_resp), W'(oh));
    if (!is_wr) chk("rdata_line", req_rdata, line);
    chk("latency", W'(edges), W'(1 + (is_wr ? 0 : 1) + BEATS + waits));
    tick();
    chk("resp_single", W'(req_resp), W'(0));
    chk("busy_idle", W'(busy), W'(0));
    model_ptr = (ch + 1) % N_CH;
  endtask

  initial begin
    rst = 1'b1;
    req_addr = '0; req_read = '0; req_write = '0; req_wdata = '0;
    bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    for (int i = 0; i < BEATS; i++) begin gap_cfg[i] = 0; beat_val[i] = '0; end
    tick(); tick();
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_grant", W'(grant), W'(0));
    chk("reset_resp", W'(req_resp), W'(0));
    chk("reset_bmem_read", W'(bmem_read), W'(0));
    chk("reset_bmem_write", W'(bmem_write), W'(0));
    chk("reset_bmem_addr", W'(bmem_addr), W'(0));
    chk("reset_bmem_wdata", W'(bmem_wdata), W'(0));
    chk("reset_rdata", req_rdata, W'(0));
    rst = 1'b0;
    tick();

    // Single read on channel 0, beats 0xA..0xD, no stalls.
    for (int i = 0; i < BEATS; i++) beat_val[i] = BUS_W'(10 + i);
    req_addr[0 +: ADDR_W] = 32'h0000_1000;
    req_read = 3'b001;
    run_txn(0, -1, 0, 1'b0, -1);
    req_read = '0;
    chk("rd_line_const", req_rdata, {64'hD, 64'hC, 64'hB, 64'hA});

    // Write on channel 1 with a 3-cycle ready stall on the second beat.
    req_addr[ADDR_W +: ADDR_W] = 32'h0000_2040;
    req_wdata[LINE_W +: LINE_W] = {64'h4, 64'h3, 64'h2, 64'h1};
    req_write = 3'b010;
    run_txn(0, 1, 3, 1'b0, -1);
    req_write = '0;
    chk("rdata_hold_after_wr", req_rdata, {64'hD, 64'hC, 64'hB, 64'hA});

    // Fairness from a fresh pointer: all three channels keep requesting reads.
    rst = 1'b1; tick(); rst = 1'b0; model_ptr = 0;
    for (int c = 0; c < N_CH; c++) req_addr[c*ADDR_W +: ADDR_W] = 32'h100 * (c + 1);
    req_read = 3'b111;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < BEATS; i++) beat_val[i] = BUS_W'(16 * t + i);
      run_txn(t % 2, -1, 0, 1'b0, -1);
    end
    req_read = '0;

    // Read and write together on channel 2: only the write is serviced.
    req_wdata[2*LINE_W +: LINE_W] = rand_line();
    req_addr[2*ADDR_W +: ADDR_W] = 32'h0000_3000;
    req_read = 3'b100; req_write = 3'b100;
    run_txn(0, -1, 0, 1'b0, -1);
    req_read = '0; req_write = '0;

    // Pointer moved past channel 2, so channel 0 beats channel 2.
    req_read = 3'b101;
    run_txn(0, -1, 0, 1'b0, -1);
    req_read = '0;

    // Reset during the second read beat, then a clean read.
    req_addr[ADDR_W +: ADDR_W] = 32'h0000_4000;
    req_read = 3'b010;
    run_txn(0, -1, 0, 1'b0, 1);
    req_read = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_resp", W'(req_resp), W'(0));
    end
    req_read = 3'b010;
    for (int i = 0; i < BEATS; i++) beat_val[i] = {$urandom, $urandom};
    run_txn(1, -1, 0, 1'b0, -1);
    req_read = '0;

    // rvalid pattern: valid, idle, idle, valid, valid, valid.
    gap_cfg[1] = 2;
    for (int i = 0; i < BEATS; i++) beat_val[i] = {$urandom, $urandom};
    req_read = 3'b001;
    run_txn(0, -1, 0, 1'b0, -1);
    req_read = '0;
    gap_cfg[1] = 0;

    // Randomized mix of channels, ops, stalls and gaps.
    for (int t = 0; t < 24; t++) begin
      logic [N_CH-1:0] mask;
      int op;
      mask = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      req_read = '0; req_write = '0;
      for (int c = 0; c < N_CH; c++) begin
        req_addr[c*ADDR_W +: ADDR_W] = $urandom;
        req_wdata[c*LINE_W +: LINE_W] = rand_line();
        if (mask[c]) begin
          op = int'($urandom_range(0, 2));
          req_read[c]  = (op != 1);
          req_write[c] = (op != 0);
        end
      end
      run_txn(int'($urandom_range(0, 2)), -1, 0, 1'b1, -1);
      req_read = '0; req_write = '0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
